// File: rtl/hazard_if.sv
// Handshake bundle between the ID/EX pipeline datapath and the hazard controller.
// The pipeline side is the master; the controller is the slave.
interface hazard_if #(
   parameter int CNT_W = 8
);
   logic [2:0]       id_rs;
   logic [2:0]       id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic [2:0]       ex_rs;
   logic [2:0]       ex_rt;
   logic [2:0]       ex_rd;
   logic             ex_mem_read;
   logic             branch_taken;
   logic [2:0]       mem_rd;
   logic             mem_reg_write;
   logic [2:0]       wb_rd;
   logic             wb_reg_write;
   logic             mem_busy;
   logic             cnt_clr;

   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_hold;
   logic             id_ex_bubble;
   logic             ex_mem_hold;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] freeze_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd,
             ex_mem_read, branch_taken, mem_rd, mem_reg_write, wb_rd,
             wb_reg_write, mem_busy, cnt_clr,
      input  pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble,
             ex_mem_hold, fwd_a, fwd_b, stall_cnt, flush_cnt, freeze_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd,
             ex_mem_read, branch_taken, mem_rd, mem_reg_write, wb_rd,
             wb_reg_write, mem_busy, cnt_clr,
      output pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble,
             ex_mem_hold, fwd_a, fwd_b, stall_cnt, flush_cnt, freeze_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/freeze sequencing, EX operand forwarding and saturating hazard counters.
//   state   | meaning
//   RUN     | normal issue; mem_busy, branch and load-use evaluated in that priority
//   LDSTALL | single bubble cycle after a load-use; load-use detection suppressed
//   FREEZE  | memory not ready; everything held, counts frozen cycles
module hazard_ctrl #(
   parameter int CNT_W = 8
) (
   input logic     clk,
   input logic     rst,
   hazard_if.slave hif
);
   typedef enum logic [1:0] {RUN, LDSTALL, FREEZE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic             load_use;
   logic             stall_inc, flush_inc, freeze_inc;
   logic             pc_write, if_id_write, if_id_flush;
   logic             id_ex_hold, id_ex_bubble, ex_mem_hold;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

   assign load_use = hif.ex_mem_read && (hif.ex_rd != 3'd0) &&
                     ((hif.id_uses_rs && (hif.id_rs == hif.ex_rd)) ||
                      (hif.id_uses_rt && (hif.id_rt == hif.ex_rd)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_hold   = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_hold  = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      freeze_inc   = 1'b0;
      // A freeze that has ended is evaluated exactly like RUN in the same cycle.
      if (hif.mem_busy) begin
         state_nxt   = FREEZE;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_hold  = 1'b1;
         ex_mem_hold = 1'b1;
         freeze_inc  = 1'b1;
      end else if (state == LDSTALL) begin
         state_nxt = RUN;
      end else if (hif.branch_taken) begin
         state_nxt    = RUN;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         flush_inc    = 1'b1;
      end else if (load_use) begin
         state_nxt    = LDSTALL;
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         stall_inc    = 1'b1;
      end else begin
         state_nxt = RUN;
      end
   end

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (hif.mem_reg_write && (hif.mem_rd != 3'd0) && (hif.mem_rd == hif.ex_rs))
         fwd_a = 2'b10;
      else if (hif.wb_reg_write && (hif.wb_rd != 3'd0) && (hif.wb_rd == hif.ex_rs))
         fwd_a = 2'b01;
      if (hif.mem_reg_write && (hif.mem_rd != 3'd0) && (hif.mem_rd == hif.ex_rt))
         fwd_b = 2'b10;
      else if (hif.wb_reg_write && (hif.wb_rd != 3'd0) && (hif.wb_rd == hif.ex_rt))
         fwd_b = 2'b01;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         freeze_cnt <= '0;
      end else if (hif.cnt_clr) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         freeze_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != CNT_MAX))   stall_cnt  <= stall_cnt + 1'b1;
         if (flush_inc && (flush_cnt != CNT_MAX))   flush_cnt  <= flush_cnt + 1'b1;
         if (freeze_inc && (freeze_cnt != CNT_MAX)) freeze_cnt <= freeze_cnt + 1'b1;
      end
   end

   // While in reset the pipeline is held quiet: nothing advances, NOPs are injected.
   assign hif.pc_write     = rst ? pc_write     : 1'b0;
   assign hif.if_id_write  = rst ? if_id_write  : 1'b0;
   assign hif.if_id_flush  = rst ? if_id_flush  : 1'b1;
   assign hif.id_ex_hold   = rst ? id_ex_hold   : 1'b0;
   assign hif.id_ex_bubble = rst ? id_ex_bubble : 1'b1;
   assign hif.ex_mem_hold  = rst ? ex_mem_hold  : 1'b0;
   assign hif.fwd_a        = rst ? fwd_a        : 2'b00;
   assign hif.fwd_b        = rst ? fwd_b        : 2'b00;
   assign hif.stall_cnt    = stall_cnt;
   assign hif.flush_cnt    = flush_cnt;
   assign hif.freeze_cnt   = freeze_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random traffic,
// with expected responses from a rule-level reference model.
module tb_hazard_ctrl;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic       rst;
      logic [2:0] id_rs;
      logic [2:0] id_rt;
      logic       id_uses_rs;
      logic       id_uses_rt;
      logic [2:0] ex_rs;
      logic [2:0] ex_rt;
      logic [2:0] ex_rd;
      logic       ex_mem_read;
      logic       branch_taken;
      logic [2:0] mem_rd;
      logic       mem_reg_write;
      logic [2:0] wb_rd;
      logic       wb_reg_write;
      logic       mem_busy;
      logic       cnt_clr;
   } stim_t;

   typedef struct packed {
      logic [9:0] ctrl;
      logic [7:0] sc;
      logic [7:0] fc;
      logic [7:0] zc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   hazard_if #(.CNT_W(CNT_W)) hif ();

   hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hif(hif));

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   int   m_stall = 0, m_flush = 0, m_freeze = 0;
   bit   m_ld = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   function automatic logic [1:0] fwd_of(input logic [2:0] src, input stim_t s);
      if (s.mem_reg_write && s.mem_rd != 0 && s.mem_rd == src) return 2'b10;
      if (s.wb_reg_write && s.wb_rd != 0 && s.wb_rd == src)    return 2'b01;
      return 2'b00;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rst = 1'b1;
      return s;
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   // Drive one cycle, predict its response, and advance the model across the next edge.
   task automatic drive_cycle(input stim_t s);
      exp_t e;
      bit   lu, pw, iw, fl, ho, bu, eh, si, fi, zi, nld;
      @(posedge clk);
      #1;
      rst                = s.rst;
      hif.id_rs          = s.id_rs;
      hif.id_rt          = s.id_rt;
      hif.id_uses_rs     = s.id_uses_rs;
      hif.id_uses_rt     = s.id_uses_rt;
      hif.ex_rs          = s.ex_rs;
      hif.ex_rt          = s.ex_rt;
      hif.ex_rd          = s.ex_rd;
      hif.ex_mem_read    = s.ex_mem_read;
      hif.branch_taken   = s.branch_taken;
      hif.mem_rd         = s.mem_rd;
      hif.mem_reg_write  = s.mem_reg_write;
      hif.wb_rd          = s.wb_rd;
      hif.wb_reg_write   = s.wb_reg_write;
      hif.mem_busy       = s.mem_busy;
      hif.cnt_clr        = s.cnt_clr;
      if (!s.rst) begin
         m_stall = 0; m_flush = 0; m_freeze = 0; m_ld = 1'b0;
         e.ctrl = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
         e.sc = 8'd0; e.fc = 8'd0; e.zc = 8'd0;
         exp_q.push_back(e);
         return;
      end
      lu = s.ex_mem_read && s.ex_rd != 0 &&
           ((s.id_uses_rs && s.id_rs == s.ex_rd) || (s.id_uses_rt && s.id_rt == s.ex_rd));
      pw = 1; iw = 1; fl = 0; ho = 0; bu = 0; eh = 0; si = 0; fi = 0; zi = 0; nld = 0;
      if (s.mem_busy) begin
         pw = 0; iw = 0; ho = 1; eh = 1; zi = 1;
      end else if (s.branch_taken && !m_ld) begin
         fl = 1; bu = 1; fi = 1;
      end else if (lu && !m_ld) begin
         pw = 0; iw = 0; bu = 1; si = 1; nld = 1;
      end
      e.ctrl = {pw, iw, fl, ho, bu, eh, fwd_of(s.ex_rs, s), fwd_of(s.ex_rt, s)};
      e.sc = 8'(m_stall); e.fc = 8'(m_flush); e.zc = 8'(m_freeze);
      exp_q.push_back(e);
      if (s.cnt_clr) begin
         m_stall = 0; m_flush = 0; m_freeze = 0;
      end else begin
         if (si) m_stall  = sat_inc(m_stall);
         if (fi) m_flush  = sat_inc(m_flush);
         if (zi) m_freeze = sat_inc(m_freeze);
      end
      m_ld = nld;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ctrl", {22'd0, hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_hold,
                           hif.id_ex_bubble, hif.ex_mem_hold, hif.fwd_a, hif.fwd_b}, {22'd0, e.ctrl});
            check("stall_cnt", {24'd0, hif.stall_cnt}, {24'd0, e.sc});
            check("flush_cnt", {24'd0, hif.flush_cnt}, {24'd0, e.fc});
            check("freeze_cnt", {24'd0, hif.freeze_cnt}, {24'd0, e.zc});
         end
      end
   end

   initial begin : stimulus
      stim_t s, lw;
      hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rs = 0; hif.id_uses_rt = 0;
      hif.ex_rs = '0; hif.ex_rt = '0; hif.ex_rd = '0; hif.ex_mem_read = 0;
      hif.branch_taken = 0; hif.mem_rd = '0; hif.mem_reg_write = 0; hif.wb_rd = '0;
      hif.wb_reg_write = 0; hif.mem_busy = 0; hif.cnt_clr = 0;

      s = idle(); s.rst = 1'b0;
      repeat (3) drive_cycle(s);

      // load-use on R3, then the add forwards from MEM/WB
      lw = idle(); lw.ex_mem_read = 1; lw.ex_rd = 3'd3; lw.id_rs = 3'd3; lw.id_uses_rs = 1;
      drive_cycle(lw);
      s = idle(); s.mem_rd = 3'd3; s.mem_reg_write = 1; drive_cycle(s);
      s = idle(); s.ex_rs = 3'd3; s.wb_rd = 3'd3; s.wb_reg_write = 1; drive_cycle(s);
      @(negedge clk);
      check("ldu_fwd_a", {30'd0, hif.fwd_a}, 32'd1);
      check("ldu_stall_cnt", {24'd0, hif.stall_cnt}, 32'd1);

      // R0 destination and unread source produce no stall
      s = idle(); s.ex_mem_read = 1; s.ex_rd = 3'd0; s.id_rs = 3'd0; s.id_uses_rs = 1; drive_cycle(s);
      s = idle(); s.ex_mem_read = 1; s.ex_rd = 3'd4; s.id_rt = 3'd4; s.id_uses_rt = 0; drive_cycle(s);

      // single taken branch
      s = idle(); s.branch_taken = 1; drive_cycle(s);
      drive_cycle(idle());

      // freeze outranks a branch held through it
      s = idle(); s.mem_busy = 1; s.branch_taken = 1;
      repeat (3) drive_cycle(s);
      s.mem_busy = 0; drive_cycle(s);
      drive_cycle(idle());
      @(negedge clk);
      check("frz_freeze_cnt", {24'd0, hif.freeze_cnt}, 32'd3);
      check("frz_flush_cnt", {24'd0, hif.flush_cnt}, 32'd2);

      // forwarding priority
      s = idle(); s.ex_rs = 3'd5; s.mem_rd = 3'd5; s.wb_rd = 3'd5;
      s.mem_reg_write = 1; s.wb_reg_write = 1; drive_cycle(s);
      s.mem_reg_write = 0; drive_cycle(s);
      s = idle(); drive_cycle(s);

      // saturate the stall counter
      for (int i = 0; i < 300; i++) begin
         drive_cycle(lw);
         drive_cycle(lw);
      end
      @(negedge clk);
      check("sat_stall_cnt", {24'd0, hif.stall_cnt}, CMAX);
      s = lw; s.cnt_clr = 1; drive_cycle(s);
      drive_cycle(idle());
      @(negedge clk);
      check("clr_stall_cnt", {24'd0, hif.stall_cnt}, 32'd0);

      // reset pulse during LDSTALL
      drive_cycle(lw);
      s = lw; s.rst = 1'b0; drive_cycle(s);
      drive_cycle(lw);
      drive_cycle(idle());

      for (int i = 0; i < 3000; i++) begin
         s = idle();
         s.rst           = ($urandom_range(0, 59) != 0);
         s.id_rs         = 3'($urandom_range(0, 7));
         s.id_rt         = 3'($urandom_range(0, 7));
         s.id_uses_rs    = 1'($urandom_range(0, 1));
         s.id_uses_rt    = 1'($urandom_range(0, 1));
         s.ex_rs         = 3'($urandom_range(0, 7));
         s.ex_rt         = 3'($urandom_range(0, 7));
         s.ex_rd         = 3'($urandom_range(0, 7));
         s.ex_mem_read   = 1'($urandom_range(0, 1));
         s.branch_taken  = (!m_ld) && ($urandom_range(0, 5) == 0);
         s.mem_rd        = 3'($urandom_range(0, 7));
         s.mem_reg_write = 1'($urandom_range(0, 1));
         s.wb_rd         = 3'($urandom_range(0, 7));
         s.wb_reg_write  = 1'($urandom_range(0, 1));
         s.mem_busy      = ($urandom_range(0, 4) == 0);
         s.cnt_clr       = ($urandom_range(0, 49) == 0);
         drive_cycle(s);
      end

      repeat (3) @(posedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
